// File: rtl/clk_div_bank.sv
// Reprogrammable clock-divider bank: NUM_CH divided clocks + enables from CLKI, with a lock/settle FSM.
// Optional single-cycle phase stepping is built when CLK_DIV_PHASE_STEP_EN is defined.
module clk_div_ch #(
  parameter int               DIV_W = 8,
  parameter logic [DIV_W-1:0] DEF   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             apply,
  input  logic             run,
  input  logic             run_nxt,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  input  logic             step,
  input  logic             dir,
  output logic             clk_out,
  output logic             clk_en
);
  logic [DIV_W-1:0] sh_div, sh_ph, act_div, act_ph, cnt;
  logic [DIV_W-1:0] div_nxt, ph_nxt, cnt_nxt;
  logic             en, en_nxt;

  // Phase lag P means starting D-P cycles into the period; P>=D degrades to 0.
  function automatic logic [DIV_W-1:0] preload(input logic [DIV_W-1:0] d, input logic [DIV_W-1:0] p);
    return (p == '0 || p >= d) ? '0 : d - p;
  endfunction

  always_comb begin
    div_nxt = apply ? sh_div : act_div;
    ph_nxt  = apply ? sh_ph  : act_ph;
    en      = act_div >= DIV_W'(2);
    en_nxt  = div_nxt >= DIV_W'(2);
    cnt_nxt = cnt;
    if (apply)           cnt_nxt = preload(sh_div, sh_ph);
    else if (!run)       cnt_nxt = preload(act_div, act_ph);
    else if (!en)        cnt_nxt = '0;
    else if (step && !dir) cnt_nxt = cnt;
    else if (step && dir)  cnt_nxt = (cnt >= act_div - DIV_W'(2)) ? cnt - (act_div - DIV_W'(2))
                                                                 : cnt + DIV_W'(2);
    else                 cnt_nxt = (cnt >= act_div - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
  end

  // Outputs are registered from next-cycle values so they line up with the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_div  <= DEF;
      sh_ph   <= '0;
      act_div <= DEF;
      act_ph  <= '0;
      cnt     <= '0;
      clk_out <= 1'b0;
      clk_en  <= 1'b0;
    end else begin
      if (wr) begin
        sh_div <= wr_div;
        sh_ph  <= wr_phase;
      end
      act_div <= div_nxt;
      act_ph  <= ph_nxt;
      cnt     <= cnt_nxt;
      clk_out <= run_nxt && en_nxt && (cnt_nxt < (div_nxt >> 1));
      clk_en  <= run_nxt && en_nxt && (cnt_nxt == '0);
    end
  end
endmodule

module clk_div_bank #(
  parameter int                        NUM_CH     = 3,
  parameter int                        DIV_W      = 8,
  parameter logic [NUM_CH*DIV_W-1:0]   DEF_DIV    = {8'd8, 8'd4, 8'd2},
  parameter int                        LOCK_DELAY = 200
) (
  input  logic              CLKI,
  input  logic              RST,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_ready,
  input  logic              phase_step,
  input  logic [3:0]        phase_ch,
  input  logic              phase_dir,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] clk_en,
  output logic              lock
);
  localparam int HC_W = $clog2(LOCK_DELAY + 1);

  typedef enum logic [1:0] {HOLD, RUN, APPLY} state_t;
  state_t          state, state_nxt;
  logic [HC_W-1:0] hold_cnt;
  logic            wr_acc, apply, run, run_nxt;
  logic [NUM_CH-1:0] step;

  assign wr_acc = cfg_wr && cfg_ready && ({1'b0, cfg_ch} < 5'(NUM_CH));

  always_ff @(posedge CLKI) begin
    if (RST) begin
      state    <= HOLD;
      hold_cnt <= HC_W'(LOCK_DELAY);
    end else begin
      state <= state_nxt;
      if (state == APPLY)                      hold_cnt <= HC_W'(LOCK_DELAY);
      else if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - HC_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (RST) state_nxt = HOLD;
    else begin
      case (state)
        HOLD:    if (wr_acc) state_nxt = APPLY;
                 else if (hold_cnt <= HC_W'(1)) state_nxt = RUN;
        RUN:     if (wr_acc) state_nxt = APPLY;
        APPLY:   state_nxt = HOLD;
        default: state_nxt = HOLD;
      endcase
    end
  end

  always_comb begin
    apply     = state == APPLY;
    run       = state == RUN;
    run_nxt   = state_nxt == RUN;
    lock      = run && !RST;
    cfg_ready = !RST && (state != APPLY);
  end

`ifdef CLK_DIV_PHASE_STEP_EN
  // A config write in the same cycle takes priority and drops the step.
  always_comb
    for (int i = 0; i < NUM_CH; i++)
      step[i] = phase_step && run && !wr_acc && (phase_ch == 4'(i));
`else
  logic unused_step;
  assign unused_step = ^{phase_step, phase_ch, phase_dir};
  assign step = '0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W (DIV_W),
      .DEF   (DEF_DIV[i*DIV_W +: DIV_W])
    ) u_ch (
      .clk      (CLKI),
      .rst      (RST),
      .apply    (apply),
      .run      (run),
      .run_nxt  (run_nxt),
      .wr       (wr_acc && (cfg_ch == 4'(i))),
      .wr_div   (cfg_div),
      .wr_phase (cfg_phase),
      .step     (step[i]),
      .dir      (phase_dir),
      .clk_out  (clk_out[i]),
      .clk_en   (clk_en[i])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: lock timing, divide/phase behaviour, invalid writes, phase steps.
module tb_clk_div_bank;
  logic       CLKI = 1'b0, RST = 1'b1;
  logic       cfg_wr = 1'b0, phase_step = 1'b0, phase_dir = 1'b0;
  logic [3:0] cfg_ch = '0, phase_ch = '0;
  logic [7:0] cfg_div = '0, cfg_phase = '0;
  logic       cfg_ready, lock;
  logic [2:0] clk_out, clk_en;
  int         n_chk = 0, n_err = 0;
  int         n, hi, per, acc;

  clk_div_bank dut (
    .CLKI(CLKI), .RST(RST), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_phase(cfg_phase), .cfg_ready(cfg_ready), .phase_step(phase_step),
    .phase_ch(phase_ch), .phase_dir(phase_dir), .clk_out(clk_out), .clk_en(clk_en),
    .lock(lock)
  );

  always #5 CLKI = ~CLKI;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_wr(input int ch, input int d, input int p);
    cfg_wr = 1'b1; cfg_ch = 4'(ch); cfg_div = 8'(d); cfg_phase = 8'(p);
    @(negedge CLKI);
    cfg_wr = 1'b0;
  endtask

  task automatic wait_lock(output int cnt);
    cnt = 0;
    do begin @(negedge CLKI); cnt++; end while (!lock && cnt < 1000);
  endtask

  task automatic wait_en(input int ch, output int cnt);
    cnt = 0;
    do begin @(negedge CLKI); cnt++; end while (!clk_en[ch] && cnt < 100);
  endtask

  // Called on a clk_en cycle; returns high count and period up to the next clk_en.
  task automatic meas(input int ch, output int h, output int p);
    h = 0; p = 0;
    do begin h += int'(clk_out[ch]); p++; @(negedge CLKI); end
    while (!clk_en[ch] && p < 100);
  endtask

  // Called on a ch2 clk_en cycle; steps mid-period and returns the gap to the next clk_en.
  task automatic step_gap(input logic dir, output int g);
    g = 0;
    repeat (2) begin @(negedge CLKI); g++; end
    phase_step = 1'b1; phase_ch = 4'd2; phase_dir = dir;
    @(negedge CLKI); g++;
    phase_step = 1'b0;
    while (!clk_en[2] && g < 100) begin @(negedge CLKI); g++; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLKI);
    check("rst_lock", lock, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_clk_out", clk_out, 0);
    check("rst_clk_en", clk_en, 0);
    RST = 1'b0;
    wait_lock(n);
    check("rst_lock_delay", n, 200);
    check("rst_first_en", clk_en, 3'b111);
    check("rst_first_out", clk_out, 3'b111);
    meas(2, hi, per);
    check("ch2_high", hi, 4);
    check("ch2_period", per, 8);

    do_wr(1, 6, 2);
    check("apply_lock", lock, 0);
    check("apply_ready", cfg_ready, 0);
    wait_lock(n);
    check("wr_lock_delay", n, 201);
    check("wr_first_en", clk_en, 3'b101);
    wait_en(1, n);
    check("ch1_phase_lag", n, 2);
    meas(1, hi, per);
    check("ch1_high", hi, 3);
    check("ch1_period", per, 6);

    do_wr(0, 5, 0);
    wait_lock(n);
    check("ch0_lock_delay", n, 201);
    check("ch0_first_en", clk_en[0], 1);
    meas(0, hi, per);
    check("ch0_odd_high", hi, 2);
    check("ch0_odd_period", per, 5);

    wait_en(2, n);
    step_gap(1'b0, n);
`ifdef CLK_DIV_PHASE_STEP_EN
    check("retard_gap", n, 9);
`else
    check("retard_gap", n, 8);
`endif
    check("retard_lock", lock, 1);
    wait_en(2, n);
    check("retard_after", n, 8);
    step_gap(1'b1, n);
`ifdef CLK_DIV_PHASE_STEP_EN
    check("advance_gap", n, 7);
`else
    check("advance_gap", n, 8);
`endif
    check("advance_lock", lock, 1);
    wait_en(2, n);
    check("advance_after", n, 8);

    do_wr(3, 2, 0);
    check("badch_lock", lock, 1);
    check("badch_ready", cfg_ready, 1);
    wait_en(2, n);
    wait_en(2, n);
    check("badch_ch2_gap", n, 8);

    do_wr(1, 1, 0);
    wait_lock(n);
    check("d1_lock_delay", n, 201);
    acc = 0;
    repeat (20) begin acc |= int'(clk_out[1] | clk_en[1]); @(negedge CLKI); end
    check("d1_stuck_low", acc, 0);

    do_wr(1, 4, 6);
    wait_lock(n);
    check("bigp_first_en", clk_en[1], 1);
    meas(1, hi, per);
    check("bigp_high", hi, 2);
    check("bigp_period", per, 4);

    do_wr(2, 8, 0);
    repeat (100) @(negedge CLKI);
    check("hold_lock", lock, 0);
    do_wr(2, 8, 0);
    wait_lock(n);
    check("hold_rewr_delay", n, 201);

    do_wr(0, 3, 0);
    repeat (50) @(negedge CLKI);
    RST = 1'b1;
    repeat (2) @(negedge CLKI);
    check("midrst_ready", cfg_ready, 0);
    check("midrst_lock", lock, 0);
    RST = 1'b0;
    wait_lock(n);
    check("midrst_delay", n, 200);
    check("midrst_first_en", clk_en, 3'b111);
    meas(1, hi, per);
    check("midrst_ch1_period", per, 4);
    wait_en(0, n);
    check("midrst_ch0_period", n, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
